// File: rtl/board_save_pkg.sv
// Shared definitions for the board saver: sector size, default board size
// and the save-sequencer state encoding.
package board_save_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int DEFAULT_N    = 800;
  localparam int DEFAULT_M    = 600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_PAD,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/board_saver_cell_packer.sv
// Collects eight cell bits LSB first into one byte and flags when the byte is
// complete; clear restarts the byte.
module cell_packer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       capture,
  input  logic       bit_in,
  output logic [7:0] data,
  output logic       full
);

  logic [3:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (capture && !full) begin
      data[count[2:0]] <= bit_in;
      count            <= count + 4'd1;
      full             <= (count == 4'd7);
    end
  end

endmodule

// File: rtl/board_saver.sv
// Streams the cell board out of the cell RAM as packed bytes in 512-byte
// sectors. Define BOARD_SAVE_POPCOUNT_EN to store a live-cell count in the
// last four bytes of the final sector.
module board_saver
  import board_save_pkg::*;
#(
  parameter int P_PARAM_N = DEFAULT_N,
  parameter int P_PARAM_M = DEFAULT_M,
  parameter int ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_first,
  output logic              out_last
);

  localparam int NM          = P_PARAM_N * P_PARAM_M;
  localparam int CW          = $clog2(NM + 1);
  localparam int DATA_BYTES  = (NM + 7) / 8;
  localparam int PAD_BYTES   = (SECTOR_BYTES - (DATA_BYTES % SECTOR_BYTES)) % SECTOR_BYTES;
  localparam int TOTAL_BYTES = DATA_BYTES + PAD_BYTES;
  localparam int BW_RAW      = $clog2(TOTAL_BYTES + 1);
  localparam int BW          = (BW_RAW < 10) ? 10 : BW_RAW;

  state_t          state, next_state;
  logic [CW-1:0]   cell_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [3:0]      slot_cnt;
  logic            cap_v, cap_live;
  logic            slot_go, cells_left, xfer, sector_end;
  logic            pk_clear, pk_capture, pk_full;
  logic [7:0]      pk_data, pad_byte;

  assign cells_left = (cell_cnt < CW'(NM));
  assign slot_go    = (state == ST_FETCH) && !slot_cnt[3];
  assign xfer       = out_valid && out_ready;
  assign sector_end = (byte_cnt[8:0] == 9'd511);
  assign pk_clear   = ((state == ST_IDLE) && start) || ((state == ST_EMIT) && xfer);
  // Bits returning after the sequencer has left FETCH (abort) are dropped.
  assign pk_capture = cap_v && (state == ST_FETCH);

  cell_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pk_clear),
    .capture (pk_capture),
    .bit_in  (cap_live & rd_data),
    .data    (pk_data),
    .full    (pk_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // NOTE: every variable assigned in an always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_FETCH;
      ST_FETCH:  if (abort) next_state = ST_FINISH;
                 else if (pk_full) next_state = ST_EMIT;
      ST_EMIT:   if (abort) next_state = ST_FINISH;
                 else if (xfer) begin
                   if (cells_left)       next_state = ST_FETCH;
                   else if (!sector_end) next_state = ST_PAD;
                   else                  next_state = ST_FINISH;
                 end
      ST_PAD:    if (abort) next_state = ST_FINISH;
                 else if (xfer && sector_end) next_state = ST_FINISH;
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cell_cnt <= '0;
      byte_cnt <= '0;
      slot_cnt <= '0;
      cap_v    <= 1'b0;
      cap_live <= 1'b0;
    end else begin
      cap_v    <= slot_go;
      cap_live <= rd_en;
      if ((state == ST_IDLE) && start) begin
        cell_cnt <= '0;
        byte_cnt <= '0;
        slot_cnt <= '0;
      end else if (slot_go) begin
        slot_cnt <= slot_cnt + 4'd1;
        if (cells_left) cell_cnt <= cell_cnt + CW'(1);
      end else if (xfer) begin
        byte_cnt <= byte_cnt + BW'(1);
        slot_cnt <= '0;
      end
    end
  end

`ifdef BOARD_SAVE_POPCOUNT_EN
  logic [31:0] pop_cnt;

  if (PAD_BYTES < 4) begin : g_pad_too_small
    $error("board_saver: popcount needs at least 4 pad bytes");
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                        pop_cnt <= '0;
    else if ((state == ST_IDLE) && start) pop_cnt <= '0;
    else if (pk_capture && cap_live && rd_data) pop_cnt <= pop_cnt + 32'd1;
  end

  // PAD only occurs in the final sector, so bytes 508..511 there carry the count.
  assign pad_byte = (byte_cnt[8:2] == 7'h7F) ? pop_cnt[{byte_cnt[1:0], 3'b000} +: 8] : 8'h00;
`else
  assign pad_byte = 8'h00;
`endif

  always_comb begin
    busy      = (state == ST_FETCH) || (state == ST_EMIT) || (state == ST_PAD);
    done      = (state == ST_FINISH);
    rd_en     = slot_go && cells_left;
    rd_addr   = rd_en ? ADDR_W'(cell_cnt) : '0;
    out_valid = (state == ST_EMIT) || (state == ST_PAD);
    out_first = out_valid && (byte_cnt[8:0] == 9'd0);
    out_last  = out_valid && sector_end;
    out_data  = 8'h00;
    if (state == ST_EMIT)     out_data = pk_data;
    else if (state == ST_PAD) out_data = pad_byte;
  end

endmodule

// File: tb/tb_board_saver.sv
// Directed bench for board_saver on an 80x60 board (600 data bytes, 424 pad
// bytes, two sectors) with a one-cycle-latency cell RAM model.
module tb_board_saver;

  localparam int N     = 80;
  localparam int M     = 60;
  localparam int NM    = N * M;
  localparam int TOTAL = 1024;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic        rd_data = 1'b0, out_ready = 1'b1;
  logic        busy, done, rd_en, out_valid, out_first, out_last;
  logic [23:0] rd_addr;
  logic [7:0]  out_data;

  int errors = 0, checks = 0, oob = 0;
  logic cells_mem [NM];

  logic [7:0] got[$];
  int   n_first, n_last, n_done, first_err, last_err, stab_err;
  bit   timed_out;
  logic busy_after, busy_during, ab_valid, ab_done;

  board_saver #(.P_PARAM_N(N), .P_PARAM_M(M), .ADDR_W(24)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      if (rd_addr >= 24'(NM)) oob++;
      else rd_data <= cells_mem[rd_addr];
    end
  end

  function automatic logic [7:0] exp_byte(input int idx, input bit sparse);
    logic [7:0] b = 8'h00;
    if (sparse) begin
      if (idx == 0)   b = 8'h01;
      if (idx == 1)   b = 8'h02;
      if (idx == 599) b = 8'h80;
`ifdef BOARD_SAVE_POPCOUNT_EN
      if (idx == 1020) b = 8'h03;
`endif
    end
    return b;
  endfunction

  task automatic load_board(input bit sparse);
    for (int i = 0; i < NM; i++) cells_mem[i] = 1'b0;
    if (sparse) begin
      cells_mem[0] = 1'b1;
      cells_mem[9] = 1'b1;
      cells_mem[NM-1] = 1'b1;
    end
  endtask

  task automatic run_save(input bit rand_ready, input int abort_at, input int budget);
    bit         held = 0, abort_pend = 0, finished = 0;
    logic [7:0] held_data = 8'h00;
    int         tail = 0;
    got.delete();
    n_first = 0; n_last = 0; n_done = 0; first_err = 0; last_err = 0; stab_err = 0;
    ab_valid = 1'bx; ab_done = 1'bx; busy_after = 1'bx;
    timed_out = 1;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; busy_during = busy;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge clk);
      abort = 1'b0;
      if (abort_pend) begin ab_valid = out_valid; ab_done = done; abort_pend = 0; end
      if (done) n_done++;
      if (finished) begin
        tail++;
        if (tail == 3) begin busy_after = busy; timed_out = 0; break; end
        continue;
      end
      if (held && out_valid && out_data !== held_data) stab_err++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && got.size() == abort_at && out_valid) begin
        abort = 1'b1; out_ready = 1'b0; abort_pend = 1;
      end
      if (out_valid && out_ready) begin
        if (out_first !== (got.size() % 512 == 0))   first_err++;
        if (out_last  !== (got.size() % 512 == 511)) last_err++;
        if (out_first) n_first++;
        if (out_last)  n_last++;
        got.push_back(out_data);
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (done) finished = 1;
    end
    abort = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_stream(input string name, input bit sparse);
    int bad = 0;
    if (timed_out) begin errors++; $display("FAIL %s timeout: done never seen", name); end
    checks++;
    if (got.size() != TOTAL) begin errors++; $display("FAIL %s byte count: got %0d want %0d", name, got.size(), TOTAL); end
    checks++;
    foreach (got[i]) if (got[i] !== exp_byte(i, sparse)) bad++;
    if (bad != 0) begin errors++; $display("FAIL %s data: %0d wrong bytes want 0", name, bad); end
    checks++;
    if (n_first != 2 || n_last != 2) begin errors++; $display("FAIL %s sector marks: first=%0d last=%0d want 2/2", name, n_first, n_last); end
    checks++;
    if (first_err + last_err != 0) begin errors++; $display("FAIL %s mark position: %0d misplaced want 0", name, first_err + last_err); end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL %s done pulses: got %0d want 1", name, n_done); end
    checks++;
    if (busy_during !== 1'b1 || busy_after !== 1'b0) begin errors++; $display("FAIL %s busy: during=%b after=%b want 1/0", name, busy_during, busy_after); end
    checks++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if ({busy, done, rd_en, out_valid, out_first, out_last, rd_addr, out_data} !== '0) begin
      errors++; $display("FAIL reset outputs: got %b want all 0", {busy, done, rd_en, out_valid, out_first, out_last, rd_addr, out_data});
    end
    checks++;
    reset_n = 1'b1;
  endtask

  task automatic test_all_zero();
    load_board(0);
    run_save(0, -1, 20000);
    check_stream("all_zero", 0);
  endtask

  task automatic test_sparse();
    load_board(1);
    run_save(0, -1, 20000);
    check_stream("sparse", 1);
    if (got.size() > 599 && (got[0] !== 8'h01 || got[1] !== 8'h02 || got[599] !== 8'h80)) begin
      errors++; $display("FAIL sparse key bytes: got %h %h %h want 01 02 80", got[0], got[1], got[599]);
    end
    checks++;
    if (oob != 0) begin errors++; $display("FAIL rd_addr range: %0d reads beyond board want 0", oob); end
    checks++;
  endtask

  task automatic test_backpressure();
    load_board(1);
    run_save(1, -1, 40000);
    check_stream("backpressure", 1);
    if (stab_err != 0) begin errors++; $display("FAIL stall stability: %0d changes want 0", stab_err); end
    checks++;
  endtask

  task automatic test_abort();
    load_board(1);
    run_save(0, 100, 20000);
    if (ab_valid !== 1'b0 || ab_done !== 1'b1) begin
      errors++; $display("FAIL abort response: out_valid=%b done=%b want 0/1", ab_valid, ab_done);
    end
    checks++;
    if (n_done != 1 || got.size() != 100) begin
      errors++; $display("FAIL abort count: done=%0d bytes=%0d want 1/100", n_done, got.size());
    end
    checks++;
    run_save(0, -1, 20000);
    check_stream("restart", 1);
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_vs_abort: busy=%b want 1", busy); end
    checks++;
    @(negedge clk); abort = 1'b0;
    if (done !== 1'b1 || rd_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_fetch: done=%b rd_en=%b out_valid=%b want 1/0/0", done, rd_en, out_valid);
    end
    checks++;
    @(negedge clk);
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b done=%b want 0/0", busy, done); end
    checks++;
  endtask

  task automatic test_reset_midfetch();
    int dones = 0;
    load_board(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    if (rd_en !== 1'b1 || rd_addr !== 24'd1) begin
      errors++; $display("FAIL fetch addr: rd_en=%b rd_addr=%0d want 1/1", rd_en, rd_addr);
    end
    checks++;
    reset_n = 1'b0;
    @(negedge clk);
    if ({busy, done, rd_en, out_valid, out_first, out_last, rd_addr, out_data} !== '0) begin
      errors++; $display("FAIL midfetch reset outputs: got %b want all 0", {busy, done, rd_en, out_valid, out_first, out_last, rd_addr, out_data});
    end
    checks++;
    reset_n = 1'b1;
    repeat (30) begin @(negedge clk); if (done || busy) dones++; end
    if (dones != 0) begin errors++; $display("FAIL midfetch reset quiet: %0d active cycles want 0", dones); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_sparse();
    test_backpressure();
    test_abort();
    test_start_abort_idle();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_saver.md
BOARD_SAVER -- requirements
Module: board_saver

Interface
REQ-001 Parameter P_PARAM_N, default 800, board columns.
REQ-002 Parameter P_PARAM_M, default 600, board rows.
REQ-003 Parameter ADDR_W, default 24, cell RAM address width.
REQ-004 Port clk, input, 1, single clock (clk_vga domain); all logic SHALL be on its rising edge.
REQ-005 Port reset_n, input, 1, synchronous active-low reset.
REQ-006 Port start, input, 1, one-cycle save request.
REQ-007 Port abort, input, 1, cancel an in-progress save.
REQ-008 Port busy, output, 1, high from the cycle after an accepted start until done.
REQ-009 Port done, output, 1, one-cycle pulse when the save completes or is aborted.
REQ-010 Port rd_en, output, 1, cell RAM read enable.
REQ-011 Port rd_addr, output, ADDR_W, cell RAM address, row-major (row*P_PARAM_N + col).
REQ-012 Port rd_data, input, 1, cell value, valid exactly 1 cycle after rd_en.
REQ-013 Port out_valid, output, 1, out_data is valid.
REQ-014 Port out_ready, input, 1, downstream sector writer accepts the byte.
REQ-015 Port out_data, output, 8, packed byte.
REQ-016 Port out_first, output, 1, byte is byte 0 of a 512-byte sector.
REQ-017 Port out_last, output, 1, byte is byte 511 of a sector.

Function
REQ-018 SHALL serialise the P_PARAM_N*P_PARAM_M cells into bytes: cell k goes to byte k/8, bit k%8 (LSB first).
REQ-019 States: IDLE, FETCH, EMIT, PAD, FINISH.
REQ-020 IDLE: start=1 loads cell and byte counters to 0 and enters FETCH; start in any other state is ignored.
REQ-021 FETCH issues 8 consecutive reads (rd_en=1, incrementing rd_addr) and captures each rd_data one cycle later; once the 8th bit is captured, it enters EMIT.
REQ-022 rd_en SHALL be 0 outside FETCH; at most 8 reads are outstanding per byte.
REQ-023 EMIT holds out_valid=1 with out_data, out_first and out_last stable until out_ready=1; transfer occurs when out_valid && out_ready.
REQ-024 After a transfer: if cells remain, go to FETCH; otherwise, if the byte count mod 512 != 0, go to PAD; otherwise go to FINISH.
REQ-025 PAD emits 0x00 bytes under the same handshake until the sector closes (out_last transferred), then goes to FINISH.
REQ-026 Defaults give 60000 data bytes plus 416 pad bytes, i.e. 118 sectors.
REQ-027 out_first = (byte count mod 512 == 0); out_last = (byte count mod 512 == 511).
REQ-028 FINISH pulses done for 1 cycle and returns to IDLE; busy=0 in IDLE.
REQ-029 abort=1 in any non-IDLE state SHALL, on the next edge, drop out_valid and rd_en, enter FINISH, and pulse done; an in-flight rd_data is discarded.
REQ-030 abort together with start in IDLE: start wins and abort is ignored.
REQ-031 Counters SHALL NOT wrap mid-save; the cell counter is ceil(log2(N*M+1)) bits wide.

Reset
REQ-032 While reset_n=0 at a clk edge: state=IDLE, and busy, done, rd_en, out_valid, out_first, out_last = 0, with rd_addr and out_data = 0.
REQ-033 Reset mid-save SHALL abandon the save without a done pulse.

Configuration
REQ-034 Macro BOARD_SAVE_POPCOUNT_EN defined: a 32-bit live-cell count is accumulated during FETCH and replaces the final 4 pad bytes of the last sector, little-endian (bytes 508..511).
REQ-035 Macro undefined: all pad bytes are 0x00 and no counter logic is present.
REQ-036 With the macro, a board whose padding is under 4 bytes SHALL fail elaboration.

Structure
REQ-037 Package board_save_pkg SHALL hold SECTOR_BYTES=512, the state enum, and default N/M.
REQ-038 One sub-module, cell_packer (8-bit shift/capture with bit count and full flag), is natural; all else lives in board_saver.

Verification
REQ-039 Default params, all cells 0, out_ready=1: exactly 60416 bytes of 0x00, 118 out_first pulses, 118 out_last pulses, one done pulse, busy low afterward.
REQ-040 Only cells 0, 9 and 479999 live: byte0=0x01, byte1=0x02, byte59999=0x80, all others 0x00.
REQ-041 out_ready toggling randomly: data is identical to REQ-040; out_data is stable while out_valid=1 and out_ready=0.
REQ-042 abort asserted at byte 1000: out_valid low the next cycle, done pulses once, and a following start restarts from byte 0.
REQ-043 With BOARD_SAVE_POPCOUNT_EN and 3 live cells: bytes 60412..60415 = 03 00 00 00.
REQ-044 reset_n low for 1 cycle mid-FETCH: all outputs 0 the next cycle, no done pulse.
